interrupt_request_ctrl: RTL and testbench
=========================================

# interrupt_request_ctrl

Collects peripheral/ALU interrupt sources, latches them as pending, applies a per-source enable mask, and drives a single prioritised request into the CPU's interrupt-handling unit. It completes the handshake with that unit: the CPU's PC-redirect pulse acknowledges the request, and the CPU's end-of-routine pulse ends service and allows the next request. It sits between the sources (ALU overflow, timers, I/O) and the CPU interrupt input.

## Interface
- NUM_SRC, 8, number of source lines (1..32)
- CAUSE_W, 3, width of cause code; NUM_SRC <= 2**CAUSE_W
- ACK_TIMEOUT, 15, cycles to wait in REQ for acknowledge before withdrawing (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- src_in  in  NUM_SRC  source lines, synchronous to clk
- mask_wr  in  1  one-cycle strobe: load mask_data into enable mask
- mask_data  in  NUM_SRC  new enable mask (1 = enabled)
- irq_ack  in  1  CPU acknowledge pulse (PC redirect taken)
- eoi  in  1  CPU end-of-interrupt pulse (routine finished)
- irq  out  1  interrupt request to CPU
- cause  out  CAUSE_W  index of source being requested/serviced
- in_service  out  1  high from ack until eoi
- pending  out  NUM_SRC  latched pending bits
- timeout_err  out  1  sticky: an ACK_TIMEOUT expiry occurred; cleared only by reset

## Operation
- States: IDLE, REQ, SERVICE. Reset -> IDLE; irq=0, cause=0, in_service=0, pending=0, mask=0 (all disabled), timeout_err=0, timeout counter=0.
- Pending capture: source event (see Configuration) sets pending[i] regardless of mask; masked bits stay pending.
- IDLE: if (pending & mask) != 0, latch cause = lowest set index (index 0 highest priority), load timeout counter, go REQ.
- REQ: irq=1. On irq_ack: clear pending[cause], go SERVICE. If mask[cause] becomes 0 before ack: withdraw (irq=0), go IDLE, pending[cause] kept. If counter expires: set timeout_err, go IDLE, pending kept. A higher-priority source arriving in REQ does not change cause (no preemption).
- SERVICE: irq=0, in_service=1, cause held. On eoi: go IDLE.
- irq_ack outside REQ and eoi outside SERVICE are ignored.
- Same-cycle set and clear of pending[cause] (new event during ack): set wins, bit stays pending.
- mask_wr takes effect the cycle after the strobe, in every state.
- Reset mid-operation returns to IDLE immediately; all pending requests are discarded.

## Timing
- All outputs registered.
- Source event at edge N -> pending bit visible after edge N; irq high after edge N+1 (from IDLE).
- irq_ack sampled at edge M -> irq low and in_service high after edge M.
- eoi sampled at edge K -> in_service low after K. A further enabled pending source raises irq after K+1, so there is one idle cycle minimum between services.
- Timeout: irq stays high for exactly ACK_TIMEOUT cycles without ack, then drops with timeout_err high on the same edge.

## Configuration
- IRQ_EDGE_DETECT_EN defined: per-source register of the previous src_in. An event is a 0->1 transition of src_in[i]. A held-high line produces one pending set only.
- Not defined: level-sensitive. An event is src_in[i]=1 on any edge, so pending re-sets every cycle while high, including immediately after ack clears it.

## Test plan
- Reset, mask=0xFF, pulse src_in[5] one cycle -> irq=1, cause=5 two edges later; irq_ack -> irq=0, in_service=1, pending[5]=0; eoi -> in_service=0.
- src_in[2] and src_in[6] events on the same edge -> cause=2 serviced first; after eoi and one idle cycle, irq=1 with cause=6.
- mask=0x00, src_in[1] event -> pending=0x02, irq stays 0; mask_wr 0x02 -> irq=1, cause=1.
- Hold REQ with no ack, ACK_TIMEOUT=15 -> irq high 15 cycles, then irq=0, timeout_err=1, pending[cause] still 1, request re-raised next cycle.
- Edge build: src_in[3] held high 10 cycles across the ack -> exactly one service. Level build: same stimulus -> pending[3] re-set and a second request after eoi.
- Assert reset while in SERVICE with pending=0x30 -> irq=0, in_service=0, pending=0 asynchronously.

Source files
------------

// File: rtl/interrupt_request_ctrl.sv
// rtl/interrupt_request_ctrl.sv - prioritised interrupt request controller with ack/eoi handshake
// Optional feature macro: IRQ_EDGE_DETECT_EN (edge-triggered sources; level-sensitive when undefined)
module interrupt_request_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int CAUSE_W     = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] enabled;
  logic [CAUSE_W-1:0] next_cause;
  logic [7:0]         cnt;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_prev <= '0;
    else       src_prev <= src_in;
  end

  assign evt = src_in & ~src_prev;
`else
  assign evt = src_in;
`endif

  assign enabled = pending & mask;

  // Scan downward so the lowest enabled index wins.
  always_comb begin
    next_cause = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) next_cause = CAUSE_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state == REQ && irq_ack) clr[cause] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= '0;
      pending     <= '0;
      cause       <= '0;
      irq         <= 1'b0;
      in_service  <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      // A new event on the acked bit in the same cycle keeps it pending.
      pending <= (pending & ~clr) | evt;
      if (mask_wr) mask <= mask_data;

      case (state)
        IDLE: begin
          if (|enabled) begin
            cause <= next_cause;
            cnt   <= 8'(ACK_TIMEOUT);
            irq   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end else if (!mask[cause]) begin
            irq   <= 1'b0;
            state <= IDLE;
          end else if (cnt <= 8'd1) begin
            irq         <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          irq        <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// tb/tb_interrupt_request_ctrl.sv - directed self-checking bench for interrupt_request_ctrl
module tb_interrupt_request_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       irq_ack;
  logic       eoi;
  logic       irq;
  logic [2:0] cause;
  logic       in_service;
  logic [7:0] pending;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int high_cnt;

  interrupt_request_ctrl #(.NUM_SRC(8), .CAUSE_W(3), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .mask_wr(mask_wr), .mask_data(mask_data),
    .irq_ack(irq_ack), .eoi(eoi), .irq(irq), .cause(cause), .in_service(in_service),
    .pending(pending), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mask(input logic [7:0] m);
    mask_wr = 1'b1; mask_data = m;
    tick();
    mask_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_in = '0; mask_wr = 1'b0; mask_data = '0; irq_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cause", 32'(cause), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_toerr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();

    // Single source 5: request two edges after the event, ack, eoi.
    load_mask(8'hFF);
    src_in = 8'h20; tick(); src_in = '0;
    check("s5_pending", 32'(pending), 32'h20);
    check("s5_irq_early", 32'(irq), 32'd0);
    tick();
    check("s5_irq", 32'(irq), 32'd1);
    check("s5_cause", 32'(cause), 32'd5);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("s5_ack_irq", 32'(irq), 32'd0);
    check("s5_ack_insvc", 32'(in_service), 32'd1);
    check("s5_ack_pending", 32'(pending), 32'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("s5_eoi_insvc", 32'(in_service), 32'd0);

    // Sources 2 and 6 together: 2 first, then 6 after one idle cycle.
    src_in = 8'h44; tick(); src_in = '0;
    check("pr_pending", 32'(pending), 32'h44);
    tick();
    check("pr_cause2", 32'(cause), 32'd2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("pr_pending_after_ack", 32'(pending), 32'h40);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("pr_idle_gap_irq", 32'(irq), 32'd0);
    tick();
    check("pr_irq6", 32'(irq), 32'd1);
    check("pr_cause6", 32'(cause), 32'd6);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Masked source stays pending; enabling it raises the request.
    load_mask(8'h00);
    src_in = 8'h02; tick(); src_in = '0;
    check("mk_pending", 32'(pending), 32'h02);
    tick();
    check("mk_irq_masked", 32'(irq), 32'd0);
    load_mask(8'h02);
    check("mk_irq_strobe_edge", 32'(irq), 32'd0);
    tick();
    check("mk_irq", 32'(irq), 32'd1);
    check("mk_cause", 32'(cause), 32'd1);

    // No ack: irq high for ACK_TIMEOUT cycles, then withdrawn with sticky error.
    high_cnt = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (irq) high_cnt++;
    end
    check("to_high_cycles", 32'(high_cnt), 32'd15);
    check("to_err_before", 32'(timeout_err), 32'd0);
    tick();
    check("to_irq", 32'(irq), 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_pending", 32'(pending), 32'h02);
    tick();
    check("to_reraise", 32'(irq), 32'd1);

    // Mask cleared while requesting: withdrawn, still pending.
    load_mask(8'h00);
    check("wd_irq_strobe_edge", 32'(irq), 32'd1);
    tick();
    check("wd_irq", 32'(irq), 32'd0);
    check("wd_pending", 32'(pending), 32'h02);
    load_mask(8'hFF);
    tick();
    check("wd_reraise", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("wd_done_pending", 32'(pending), 32'h00);

    // Source 3 held high 10 edges across the ack.
    src_in = 8'h08; tick();
    tick();
    check("hold_cause", 32'(cause), 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    check("hold_pending_ack", 32'(pending), 32'h00);
`else
    check("hold_pending_ack", 32'(pending), 32'h08);
`endif
    repeat (7) tick();
    src_in = '0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("hold_eoi_insvc", 32'(in_service), 32'd0);
    tick();
`ifdef IRQ_EDGE_DETECT_EN
    check("hold_second_irq", 32'(irq), 32'd0);
`else
    check("hold_second_irq", 32'(irq), 32'd1);
    check("hold_second_cause", 32'(cause), 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
`endif
    check("hold_pending_end", 32'(pending), 32'h00);

    // Asynchronous reset while in SERVICE with pending 0x30.
    src_in = 8'h10; tick(); src_in = '0;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src_in = 8'h30; tick(); src_in = '0;
    check("ar_pending_before", 32'(pending), 32'h30);
    check("ar_insvc_before", 32'(in_service), 32'd1);
    check("ar_toerr_before", 32'(timeout_err), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("ar_irq", 32'(irq), 32'd0);
    check("ar_insvc", 32'(in_service), 32'd0);
    check("ar_pending", 32'(pending), 32'h00);
    check("ar_toerr", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("ar_irq_after", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
